// File: rtl/leitor_registrador.sv
// leitor_registrador: 2-entry skid buffer between a register stage and a consumer
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-high reset
//   valid_i  - upstream word present on data_i
//   data_i   - upstream word
//   ready_o  - registered accept flag, doubles as upstream load enable
//   valid_o  - data_o holds a valid word
//   data_o   - oldest stored word, straight from the main register
//   ready_i  - consumer takes data_o this cycle
//   count_o  - stored words (0..2), equals the state encoding
//   parity_o - registered even parity of data_o, present only with LEITOR_PARITY_EN
module leitor_registrador #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [1:0]            count_o
`ifdef LEITOR_PARITY_EN
    ,
    output logic                  parity_o
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic                  ready_q, wr, rd;
    assign wr      = valid_i & ready_q;
    assign rd      = valid_o & ready_i;
    assign ready_o = ready_q;
    assign valid_o = state_q != EMPTY;
    assign data_o  = main_q;
    assign count_o = state_q;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                state_d = wr ? ONE : EMPTY;
                main_d  = wr ? data_i : main_q;
            end
            ONE: begin
                state_d = (wr && !rd) ? FULL : (!wr && rd) ? EMPTY : ONE;
                main_d  = (wr && rd) ? data_i : main_q;
                skid_d  = (wr && !rd) ? data_i : skid_q;
            end
            FULL: begin
                state_d = rd ? ONE : FULL;
                main_d  = rd ? skid_q : main_q;
            end
            default: state_d = EMPTY;
        endcase
    end
    // ready is derived from the next state so it is registered yet still
    // equals count<2 in every cycle outside reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= state_d != FULL;
        end
    end
`ifdef LEITOR_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) parity_o <= 1'b0;
        else       parity_o <= ^main_d;
    end
`endif
endmodule

// File: doc/leitor_registrador.md
LEITOR_REGISTRADOR -- requirements
Module: leitor_registrador

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of one data word.
REQ-002 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 valid_i  input  1  SHALL flag that data_i holds a word offered by the upstream register stage.
REQ-005 data_i  input  DATA_WIDTH  SHALL carry the upstream word.
REQ-006 ready_o  output  1  SHALL flag that the block accepts a word this cycle; it also serves as the load enable for the upstream stage.
REQ-007 valid_o  output  1  SHALL flag that data_o holds a valid word for the consumer.
REQ-008 data_o  output  DATA_WIDTH  SHALL carry the oldest stored word.
REQ-009 ready_i  input  1  SHALL flag that the consumer takes data_o this cycle.
REQ-010 count_o  output  2  SHALL report stored words (0..2).
REQ-011 parity_o  output  1  SHALL exist only when LEITOR_PARITY_EN is defined (see Configuration).

Function
REQ-012 The block SHALL be a 2-entry skid buffer: main register (drives data_o) plus skid register.
REQ-013 Write handshake SHALL occur on a rising edge with valid_i=1 and ready_o=1; read handshake SHALL occur on a rising edge with valid_o=1 and ready_i=1.
REQ-014 ready_o SHALL be registered and SHALL equal 1 exactly when count_o<2; no combinational path from ready_i to ready_o.
REQ-015 valid_o SHALL equal 1 exactly when count_o>0; data_o SHALL come directly from the main register.
REQ-016 State machine SHALL have states EMPTY(0), ONE(1), FULL(2); count_o SHALL encode the state.
REQ-017 EMPTY: write -> ONE, word loaded into main; no write -> stay.
REQ-018 ONE: write only -> FULL, word loaded into skid; read only -> EMPTY; write and read together -> stay ONE, new word loaded into main.
REQ-019 FULL: read -> ONE, skid word moves into main; no read -> stay, both registers hold; valid_i ignored (ready_o=0).
REQ-020 Latency SHALL be one cycle: a word written at edge N SHALL appear on data_o after edge N when the buffer was EMPTY.
REQ-021 Sustained throughput SHALL be one word per cycle when valid_i and ready_i both stay high.
REQ-022 Word order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-023 data_o while valid_o=0 SHALL hold the last value and is don't-care for consumers.
REQ-024 A write attempted while ready_o=0 SHALL have no effect.

Reset
REQ-025 rst_i=1 SHALL immediately, without a clock edge, force state EMPTY, count_o=0, valid_o=0, ready_o=0, main and skid registers 0, parity_o=0 when present.
REQ-026 ready_o SHALL rise to 1 on the first rising edge after rst_i deasserts; no handshake SHALL complete while rst_i=1.
REQ-027 Reset mid-transfer SHALL discard all stored words.

Configuration
REQ-028 Macro LEITOR_PARITY_EN defined: parity_o SHALL be a registered even-parity bit (XOR of all bits) of data_o, updated on the same edge as data_o.
REQ-029 Macro LEITOR_PARITY_EN undefined: parity_o and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset: assert rst_i mid-cycle with 2 words stored -> count_o=0, valid_o=0, ready_o=0 immediately; ready_o=1 one edge after release.
REQ-031 Single word: DATA_WIDTH=32, write 0xDEADBEEF with ready_i=0 -> next cycle valid_o=1, data_o=0xDEADBEEF, count_o=1.
REQ-032 Fill: ready_i=0, write 0x1 then 0x2 -> count_o=2, ready_o=0, data_o=0x1; offered 0x3 not taken; then ready_i=1 for 2 cycles -> outputs 0x1, 0x2, count_o=0.
REQ-033 Streaming: valid_i=ready_i=1, writes 0..99 -> data_o outputs 0..99 in order, one per cycle, count_o stays 1.
REQ-034 Random: random valid_i/ready_i, 1000 words -> scoreboard matches order and values, count_o never exceeds 2.
REQ-035 Parity (macro defined): write 0x00000007 -> parity_o=1; write 0x00000003 -> parity_o=0.
